// File: rtl/keypad_pkg.sv
// Shared types and key legend for the keypad matrix scanner.
// Legend codes are row*COLS+col for the standard 4x4 pad layout.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_t;

   localparam int KEY_NULL = 0;

   // Row 0: 1 2 3 A / Row 1: 4 5 6 B / Row 2: 7 8 9 C / Row 3: * 0 # D
   localparam int T_1    = 0;
   localparam int T_2    = 1;
   localparam int T_3    = 2;
   localparam int T_A    = 3;
   localparam int T_4    = 4;
   localparam int T_5    = 5;
   localparam int T_6    = 6;
   localparam int T_B    = 7;
   localparam int T_7    = 8;
   localparam int T_8    = 9;
   localparam int T_9    = 10;
   localparam int T_C    = 11;
   localparam int T_ASTE = 12;
   localparam int T_0    = 13;
   localparam int T_HASH = 14;
   localparam int T_D    = 15;

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous row lines; idles high like
// an unpressed matrix.
module keypad_row_sync #(
   parameter int ROWS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ROWS-1:0] rows,
   output logic [ROWS-1:0] rows_sync
);

   logic [ROWS-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= '1;
         rows_sync <= '1;
      end else begin
         meta      <= rows;
         rows_sync <= meta;
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans an active-low ROWS x COLS key matrix, debounces press/release and
// posts events through a one-deep valid/ready register.
// Optional auto-repeat is built when KEYPAD_TYPEMATIC_EN is defined.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SETTLE_CYCLES   = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   localparam int CODE_W         = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ROWS-1:0]   rows,
   output logic [COLS-1:0]   cols,
   output logic              key_down,
   output logic [CODE_W-1:0] key_code,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CODE_W-1:0] evt_code,
   output logic              evt_press,
   output logic              evt_repeat,
   output logic              evt_dropped
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int ST_W  = $clog2(SETTLE_CYCLES);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE_CYCLES < 3 ||
       DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keypad_matrix_scanner: parameter out of range");
   end

   logic [ROWS-1:0]   rows_sync;
   kp_state_t         state, state_nx;
   logic [COL_W-1:0]  col, col_nx, col_next;
   logic [ST_W-1:0]   settle_cnt, settle_nx;
   logic [DB_W-1:0]   db_cnt, db_nx;
   logic [ROW_W-1:0]  row_idx, row_nx, low_row;
   logic              any_low, row_low;
   logic              key_down_nx;
   logic [CODE_W-1:0] key_code_nx, cur_code;
   logic              post, post_press;
   logic [CODE_W-1:0] post_code;
   logic              accept;

   keypad_row_sync #(.ROWS(ROWS)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .rows      (rows),
      .rows_sync (rows_sync)
   );

   assign cols     = ~(COLS'(1) << col);
   assign col_next = (col == COL_W'(COLS-1)) ? '0 : col + 1'b1;
   assign row_low  = ~rows_sync[row_idx];
   assign cur_code = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col);
   assign accept   = evt_valid & evt_ready;

   // Descending scan so the lowest-index low row is the one that sticks.
   always_comb begin
      low_row = '0;
      any_low = 1'b0;
      for (int i = ROWS-1; i >= 0; i--) begin
         if (!rows_sync[i]) begin
            low_row = ROW_W'(i);
            any_low = 1'b1;
         end
      end
   end

`ifdef KEYPAD_TYPEMATIC_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
   logic             rep_started, rep_started_nx;
   logic             post_repeat;
`endif

   always_comb begin
      state_nx    = state;
      col_nx      = col;
      settle_nx   = settle_cnt;
      db_nx       = db_cnt;
      row_nx      = row_idx;
      key_down_nx = key_down;
      key_code_nx = key_code;
      post        = 1'b0;
      post_press  = 1'b0;
      post_code   = cur_code;
`ifdef KEYPAD_TYPEMATIC_EN
      post_repeat    = 1'b0;
      rep_cnt_nx     = rep_cnt;
      rep_started_nx = rep_started;
`endif
      unique case (state)
         SCAN: begin
            if (settle_cnt == ST_W'(SETTLE_CYCLES-1)) begin
               settle_nx = '0;
               if (any_low) begin
                  row_nx   = low_row;
                  db_nx    = '0;
                  state_nx = DEBOUNCE;
               end else begin
                  col_nx = col_next;
               end
            end else begin
               settle_nx = settle_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (!row_low) begin
               state_nx  = SCAN;
               db_nx     = '0;
               settle_nx = '0;
               col_nx    = col_next;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES-1)) begin
               post        = 1'b1;
               post_press  = 1'b1;
               key_down_nx = 1'b1;
               key_code_nx = cur_code;
               db_nx       = '0;
               state_nx    = HELD;
`ifdef KEYPAD_TYPEMATIC_EN
               rep_cnt_nx     = '0;
               rep_started_nx = 1'b0;
`endif
            end else begin
               db_nx = db_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!row_low) begin
               db_nx    = '0;
               state_nx = REL_DB;
            end
`ifdef KEYPAD_TYPEMATIC_EN
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            else if ((!rep_started && rep_cnt == REP_W'(REPEAT_DELAY-1)) ||
                     ( rep_started && rep_cnt == REP_W'(REPEAT_PERIOD-1))) begin
               post           = 1'b1;
               post_press     = 1'b1;
               post_repeat    = 1'b1;
               post_code      = key_code;
               rep_cnt_nx     = '0;
               rep_started_nx = 1'b1;
            end else begin
               rep_cnt_nx = rep_cnt + 1'b1;
            end
`endif
         end
         REL_DB: begin
            if (row_low) begin
               state_nx = HELD;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES-1)) begin
               post        = 1'b1;
               post_press  = 1'b0;
               key_down_nx = 1'b0;
               db_nx       = '0;
               settle_nx   = '0;
               col_nx      = col_next;
               state_nx    = SCAN;
`ifdef KEYPAD_TYPEMATIC_EN
               rep_cnt_nx     = '0;
               rep_started_nx = 1'b0;
`endif
            end else begin
               db_nx = db_cnt + 1'b1;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SCAN;
         col        <= '0;
         settle_cnt <= '0;
         db_cnt     <= '0;
         row_idx    <= '0;
         key_down   <= 1'b0;
         key_code   <= CODE_W'(KEY_NULL);
      end else begin
         state      <= state_nx;
         col        <= col_nx;
         settle_cnt <= settle_nx;
         db_cnt     <= db_nx;
         row_idx    <= row_nx;
         key_down   <= key_down_nx;
         key_code   <= key_code_nx;
      end
   end

   // A full register that is not being drained keeps its event; the newcomer is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid   <= 1'b0;
         evt_code    <= CODE_W'(KEY_NULL);
         evt_press   <= 1'b0;
         evt_dropped <= 1'b0;
      end else begin
         evt_dropped <= 1'b0;
         if (post && (!evt_valid || accept)) begin
            evt_valid <= 1'b1;
            evt_code  <= post_code;
            evt_press <= post_press;
         end else begin
            if (post) begin
               evt_dropped <= 1'b1;
            end
            if (accept) begin
               evt_valid <= 1'b0;
            end
         end
      end
   end

`ifdef KEYPAD_TYPEMATIC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt     <= '0;
         rep_started <= 1'b0;
         evt_repeat  <= 1'b0;
      end else begin
         rep_cnt     <= rep_cnt_nx;
         rep_started <= rep_started_nx;
         if (post && (!evt_valid || accept)) begin
            evt_repeat <= post_repeat;
         end
      end
   end
`else
   assign evt_repeat = 1'b0;
`endif

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised successor to the fixed 4x4 keypad decoder; scans a ROWS x COLS active-low key matrix by rotating a single low column.
- Debounces both press and release.
- Emits press/release events through a valid/ready handshake and holds a live key_down/key_code view.
- Sits between the keypad pins and the command/entry logic.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 4, number of column outputs (2..8).
- SETTLE_CYCLES, 16, clocks a column is driven before its rows are sampled (>=3, covers the 2-flop sync).
- DEBOUNCE_CYCLES, 500000, clocks a level must be stable to accept a press or release (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, clocks held before the first auto-repeat (used only with the macro).
- REPEAT_PERIOD, 5000000, clocks between subsequent auto-repeats (used only with the macro).
- CODE_W is a localparam: $clog2(ROWS*COLS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rows  in  ROWS  raw row lines, active-low, asynchronous to clk
- cols  out  COLS  column drive; exactly one bit low
- key_down  out  1  debounced key currently held
- key_code  out  CODE_W  code of held key = row*COLS+col
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_code  out  CODE_W  event key code
- evt_press  out  1  1=press, 0=release
- evt_repeat  out  1  event is an auto-repeat (0 without macro)
- evt_dropped  out  1  one-cycle pulse: an event was lost

Behaviour:
- Reset (async assert, sync release): cols = all ones except bit0 low; state SCAN; all counters 0; key_down, key_code, evt_valid, evt_code, evt_press, evt_repeat, evt_dropped = 0.
- Rows pass through a 2-flop synchroniser that resets to all ones. All decisions below use the synchronised rows.
- SCAN:
  - Settle counter runs 0..SETTLE_CYCLES-1, then rows are sampled.
  - Any row low: latch the column and the lowest-index low row, go to DEBOUNCE; the column stays frozen.
  - No row low: advance to the next column (COLS-1 wraps to 0) and restart settle.
- DEBOUNCE:
  - Counter increments each clock while the latched row stays low.
  - Row goes high: return to SCAN with counter=0 and the next column.
  - Reaching DEBOUNCE_CYCLES-1 with row still low: on the next edge post a press event, set key_down=1, load key_code, go to HELD.
- HELD:
  - Column stays frozen; other rows are ignored (no rollover).
  - Latched row high: go to REL_DB with counter=0.
- REL_DB:
  - Row low again: return to HELD (no event).
  - Row high for DEBOUNCE_CYCLES clocks: post a release event, key_down=0 (key_code keeps its last value), go to SCAN at the next column.
- Event register (1 deep):
  - Accepted by the consumer when evt_valid&&evt_ready.
  - Posting into an empty register, or in the same cycle it is accepted: load and set evt_valid.
  - Posting while full and not accepting: new event discarded, old one kept, evt_dropped pulses 1 cycle.
  - evt_code, evt_press and evt_repeat remain stable while evt_valid=1.
- Reset mid-scan or mid-hold: immediate return to reset values; no release event is produced.
- Worst-case press latency to evt_valid: 2 (sync) + COLS*SETTLE_CYCLES + DEBOUNCE_CYCLES.

Optional Feature:
- KEYPAD_TYPEMATIC_EN defined:
  - In HELD a repeat counter runs. At REPEAT_DELAY it posts a press event with evt_repeat=1, then posts one every REPEAT_PERIOD.
  - Counter is cleared on leaving HELD. REL_DB pauses it; a return to HELD resumes it.
- Undefined: no repeat logic is built, evt_repeat is tied 0, and the REPEAT_* parameters are ignored.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (SCAN, DEBOUNCE, HELD, REL_DB).
  - KEY_NULL constant.
  - 4x4 legend constants T_0..T_9, T_A..T_D, T_ASTE, T_HASH, expressed as row*COLS+col codes for the default geometry.
- Sub-module keypad_row_sync: ROWS-wide 2-flop synchroniser, reset to ones.

Test Plan (bench uses SETTLE_CYCLES=3, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10):
- Idle rows=4'hF -> cols cycle 1110,1101,1011,0111,1110 every 3 clocks; no events.
- Clean press row1/col2, evt_ready=1 -> one press event, code 6, evt_press=1; key_down=1; cols frozen at 1011. Release -> after 8 stable clocks one release event, code 6, evt_press=0; scan resumes at col3.
- 3-clock glitch on row0 during DEBOUNCE -> no event; scan continues at the next column.
- evt_ready=0, press then release of code 5 -> press held in the register, release dropped, evt_dropped pulses once; after ready, only the press event is seen.
- rows 1 and 3 low on col0 -> code 4 reported (lowest row wins).
- rst_n low while HELD -> outputs 0 immediately; no release event after reset. With KEYPAD_TYPEMATIC_EN, holding code 0 for 70 clocks -> press, then repeats at +40 and +50 clocks with evt_repeat=1.
